// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared-RAM arbiter: three requester ports, CPU stall lines and the RAM port.
// The arbiter connects through the slave modport; requesters and the RAM connect through master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              x_req;
    logic              x_we;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_wdata;
    logic              x_ack;
    logic [DATA_W-1:0] x_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              stall_if;
    logic              stall_mem;
    logic              busy;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  x_req, x_we, x_addr, x_wdata,
        output x_ack, x_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata,
        input  i_req, i_addr,
        output i_ack, i_rdata,
        output stall_if, stall_mem, busy,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output x_req, x_we, x_addr, x_wdata,
        input  x_ack, x_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata,
        output i_req, i_addr,
        input  i_ack, i_rdata,
        input  stall_if, stall_mem, busy,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (loader X, CPU data D, instruction fetch I) sharing one single-port
// synchronous RAM through an IDLE -> ACC -> RSP schedule, with fetch starvation relief.
module mem_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACC   = 2'd1;
    localparam logic [1:0] ST_RSP   = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_X    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_I    = 2'd3;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        starve_q, starve_d;
    logic [DATA_W-1:0] x_rdata_q, d_rdata_q, i_rdata_q;

    logic              x_cand_s, d_cand_s, i_cand_s;
    logic [1:0]        win_s;
    logic              arb_point_s;
    logic              rsp_s;
    logic              x_ack_s, d_ack_s, i_ack_s;
    logic              rd_ack_s;

    // Candidate filtering and priority pick; the current owner sits out its own RSP cycle
    always_comb begin
        x_cand_s    = bus.x_req && (owner_q != OWN_X);
        d_cand_s    = bus.d_req && (owner_q != OWN_D);
        i_cand_s    = bus.i_req && (owner_q != OWN_I);
        arb_point_s = (state_q == ST_IDLE) || (state_q == ST_RSP);
        if (i_cand_s && (starve_q == STARVE_LIM)) begin
            win_s = OWN_I;
        end else if (x_cand_s) begin
            win_s = OWN_X;
        end else if (d_cand_s) begin
            win_s = OWN_D;
        end else if (i_cand_s) begin
            win_s = OWN_I;
        end else begin
            win_s = OWN_NONE;
        end
    end

    // Next-state, owner and request latch
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE, ST_RSP: begin
                owner_d = win_s;
                case (win_s)
                    OWN_X: begin
                        state_d = ST_ACC;
                        addr_d  = bus.x_addr;
                        we_d    = bus.x_we;
                        wdata_d = bus.x_wdata;
                    end
                    OWN_D: begin
                        state_d = ST_ACC;
                        addr_d  = bus.d_addr;
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                    end
                    OWN_I: begin
                        state_d = ST_ACC;
                        addr_d  = bus.i_addr;
                        we_d    = 1'b0;
                        wdata_d = {DATA_W{1'b0}};
                    end
                    default: begin
                        state_d = ST_IDLE;
                        addr_d  = {ADDR_W{1'b0}};
                        we_d    = 1'b0;
                        wdata_d = {DATA_W{1'b0}};
                    end
                endcase
            end
            ST_ACC: begin
                state_d = ST_RSP;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
                addr_d  = {ADDR_W{1'b0}};
                we_d    = 1'b0;
                wdata_d = {DATA_W{1'b0}};
            end
        endcase
    end

    // Starvation counter: counts X/D grants that bypassed a pending fetch
    always_comb begin
        starve_d = starve_q;
        if (!bus.i_req) begin
            starve_d = 4'd0;
        end else if (arb_point_s && (win_s == OWN_I)) begin
            starve_d = 4'd0;
        end else if (arb_point_s && ((win_s == OWN_X) || (win_s == OWN_D))) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // State and data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            addr_q    <= {ADDR_W{1'b0}};
            we_q      <= 1'b0;
            wdata_q   <= {DATA_W{1'b0}};
            starve_q  <= 4'd0;
            x_rdata_q <= {DATA_W{1'b0}};
            d_rdata_q <= {DATA_W{1'b0}};
            i_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            if (x_ack_s && rd_ack_s) begin
                x_rdata_q <= bus.ram_rdata;
            end
            if (d_ack_s && rd_ack_s) begin
                d_rdata_q <= bus.ram_rdata;
            end
            if (i_ack_s && rd_ack_s) begin
                i_rdata_q <= bus.ram_rdata;
            end
        end
    end

    assign rsp_s    = (state_q == ST_RSP);
    assign rd_ack_s = rsp_s && !we_q;
    assign x_ack_s  = rsp_s && (owner_q == OWN_X);
    assign d_ack_s  = rsp_s && (owner_q == OWN_D);
    assign i_ack_s  = rsp_s && (owner_q == OWN_I);

    assign bus.x_ack   = x_ack_s;
    assign bus.d_ack   = d_ack_s;
    assign bus.i_ack   = i_ack_s;
    // Read data bypasses the holding register during the owner's read ack
    assign bus.x_rdata = (x_ack_s && rd_ack_s) ? bus.ram_rdata : x_rdata_q;
    assign bus.d_rdata = (d_ack_s && rd_ack_s) ? bus.ram_rdata : d_rdata_q;
    assign bus.i_rdata = (i_ack_s && rd_ack_s) ? bus.ram_rdata : i_rdata_q;

    assign bus.stall_if  = bus.i_req && !i_ack_s;
    assign bus.stall_mem = bus.d_req && !d_ack_s;
    assign bus.busy      = (state_q != ST_IDLE);

    assign bus.ram_en    = (state_q == ST_ACC);
    assign bus.ram_we    = (state_q == ST_ACC) && we_q;
    assign bus.ram_addr  = (state_q == ST_ACC) ? addr_q  : {ADDR_W{1'b0}};
    assign bus.ram_wdata = (state_q == ST_ACC) ? wdata_q : {DATA_W{1'b0}};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a read-first synchronous RAM model behind the arbiter,
// with hand-computed cycle-by-cycle expectations.
module tb_mem_port_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Read-first single-port RAM
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        logic sx, sd, si;
        int   n;
        n = 0;
        while ((bus.x_req || bus.d_req || bus.i_req || bus.busy) && n < 60) begin
            sx = bus.x_ack;
            sd = bus.d_ack;
            si = bus.i_ack;
            cyc();
            if (sx) bus.x_req = 1'b0;
            if (sd) begin bus.d_req = 1'b0; bus.d_we = 1'b0; end
            if (si) bus.i_req = 1'b0;
            n++;
        end
        #1;
        chk({tag, "_done"}, 32'(n < 60), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_ack;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 32'd0;
        mem[5] = 32'hDEADBEEF;
        mem[3] = 32'hAAAAAAAA;
        mem[4] = 32'h44444444;

        // Reset held with every request raised
        bus.x_req = 1'b1; bus.x_we = 1'b0; bus.x_addr = 11'd5; bus.x_wdata = 32'd0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 11'd4; bus.d_wdata = 32'd0;
        bus.i_req = 1'b1; bus.i_addr = 11'd3;
        repeat (3) cyc();
        chk("rst_x_ack", bus.x_ack, 32'd0);
        chk("rst_d_ack", bus.d_ack, 32'd0);
        chk("rst_i_ack", bus.i_ack, 32'd0);
        chk("rst_ram_en", bus.ram_en, 32'd0);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_x_rdata", bus.x_rdata, 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_busy_c0", bus.busy, 32'd0);
        cyc();
        chk("rel_ram_en_c1", bus.ram_en, 32'd1);
        chk("rel_ram_addr_c1", 32'(bus.ram_addr), 32'd5);
        cyc();
        chk("rel_x_ack_c2", bus.x_ack, 32'd1);
        chk("rel_x_rdata_c2", bus.x_rdata, 32'hDEADBEEF);
        drain("rel_drain");
        chk("rel_d_rdata", bus.d_rdata, 32'h44444444);
        chk("rel_i_rdata", bus.i_rdata, 32'hAAAAAAAA);

        // Single fetch
        bus.i_req = 1'b1; bus.i_addr = 11'd5;
        #1;
        chk("sf_stall_c0", bus.stall_if, 32'd1);
        cyc();
        chk("sf_ram_en_c1", bus.ram_en, 32'd1);
        chk("sf_ram_we_c1", bus.ram_we, 32'd0);
        chk("sf_ram_addr_c1", 32'(bus.ram_addr), 32'd5);
        chk("sf_stall_c1", bus.stall_if, 32'd1);
        cyc();
        chk("sf_i_ack_c2", bus.i_ack, 32'd1);
        chk("sf_i_rdata_c2", bus.i_rdata, 32'hDEADBEEF);
        chk("sf_stall_c2", bus.stall_if, 32'd0);
        cyc();
        bus.i_req = 1'b0;
        #1;
        chk("sf_i_ack_c3", bus.i_ack, 32'd0);
        chk("sf_busy_c3", bus.busy, 32'd0);
        chk("sf_i_rdata_hold", bus.i_rdata, 32'hDEADBEEF);

        // Write-then-fetch collision on address 3
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 11'd3; bus.d_wdata = 32'h12345678;
        bus.i_req = 1'b1; bus.i_addr = 11'd3;
        #1;
        chk("wf_stall_mem_c0", bus.stall_mem, 32'd1);
        cyc();
        chk("wf_ram_we_c1", bus.ram_we, 32'd1);
        chk("wf_ram_addr_c1", 32'(bus.ram_addr), 32'd3);
        chk("wf_ram_wdata_c1", bus.ram_wdata, 32'h12345678);
        cyc();
        chk("wf_d_ack_c2", bus.d_ack, 32'd1);
        chk("wf_i_ack_c2", bus.i_ack, 32'd0);
        chk("wf_d_rdata_c2", bus.d_rdata, 32'h44444444);
        chk("wf_stall_mem_c2", bus.stall_mem, 32'd0);
        cyc();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        #1;
        chk("wf_ram_en_c3", bus.ram_en, 32'd1);
        chk("wf_ram_we_c3", bus.ram_we, 32'd0);
        chk("wf_ram_wdata_c3", bus.ram_wdata, 32'd0);
        cyc();
        chk("wf_i_ack_c4", bus.i_ack, 32'd1);
        chk("wf_i_rdata_c4", bus.i_rdata, 32'h12345678);
        cyc();
        bus.i_req = 1'b0;
        #1;
        chk("wf_busy_c5", bus.busy, 32'd0);

        // Priority X over D
        bus.x_req = 1'b1; bus.x_addr = 11'd3;
        bus.d_req = 1'b1; bus.d_addr = 11'd5;
        cyc();
        chk("pr_ram_addr_c1", 32'(bus.ram_addr), 32'd3);
        cyc();
        chk("pr_x_ack_c2", bus.x_ack, 32'd1);
        chk("pr_d_ack_c2", bus.d_ack, 32'd0);
        chk("pr_x_rdata_c2", bus.x_rdata, 32'h12345678);
        chk("pr_d_rdata_c2", bus.d_rdata, 32'h44444444);
        chk("pr_stall_mem_c2", bus.stall_mem, 32'd1);
        cyc();
        bus.x_req = 1'b0;
        #1;
        chk("pr_ram_addr_c3", 32'(bus.ram_addr), 32'd5);
        chk("pr_d_rdata_c3", bus.d_rdata, 32'h44444444);
        cyc();
        chk("pr_d_ack_c4", bus.d_ack, 32'd1);
        chk("pr_x_ack_c4", bus.x_ack, 32'd0);
        chk("pr_d_rdata_c4", bus.d_rdata, 32'hDEADBEEF);
        cyc();
        bus.d_req = 1'b0;
        #1;
        chk("pr_busy_c5", bus.busy, 32'd0);
        chk("pr_d_rdata_hold", bus.d_rdata, 32'hDEADBEEF);

        // Starvation relief with STARVE_MAX=2: X, D, I, X, D, I
        bus.x_req = 1'b1; bus.x_addr = 11'd3;
        bus.d_req = 1'b1; bus.d_addr = 11'd5;
        bus.i_req = 1'b1; bus.i_addr = 11'd3;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk($sformatf("sv_ram_en_%0d", k), bus.ram_en, 32'd1);
            cyc();
            case (k % 3)
                0:       exp_ack = 3'b100;
                1:       exp_ack = 3'b010;
                default: exp_ack = 3'b001;
            endcase
            chk($sformatf("sv_acks_%0d", k), 32'({bus.x_ack, bus.d_ack, bus.i_ack}), 32'(exp_ack));
        end
        drain("sv_drain");

        // Reset during ACC of a write to address 7
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 11'd7; bus.d_wdata = 32'hCAFEF00D;
        cyc();
        chk("ra_ram_we_c1", bus.ram_we, 32'd1);
        rst = 1'b0;
        #1;
        chk("ra_ram_en_rst", bus.ram_en, 32'd0);
        chk("ra_busy_rst", bus.busy, 32'd0);
        cyc();
        chk("ra_d_ack_rst", bus.d_ack, 32'd0);
        chk("ra_mem7_unwritten", mem[7], 32'd0);
        chk("ra_x_rdata_clr", bus.x_rdata, 32'd0);
        chk("ra_d_rdata_clr", bus.d_rdata, 32'd0);
        chk("ra_i_rdata_clr", bus.i_rdata, 32'd0);
        cyc();
        rst = 1'b1;
        #1;
        chk("ra_busy_rel", bus.busy, 32'd0);
        cyc();
        chk("ra_ram_we_r1", bus.ram_we, 32'd1);
        chk("ra_ram_addr_r1", 32'(bus.ram_addr), 32'd7);
        cyc();
        chk("ra_d_ack_r2", bus.d_ack, 32'd1);
        cyc();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        #1;
        chk("ra_mem7_written", mem[7], 32'hCAFEF00D);
        chk("ra_busy_r3", bus.busy, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
